// File: rtl/psum_pkg.sv
// Shared types and helpers for the channel-pass psum accumulator.
// Holds the FSM state enum, default datapath widths and the psum sign-extension helper.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } psum_acc_state_t;

    localparam int PSUM_DWIDTH = 25;
    localparam int PSUM_AWIDTH = 32;

    function automatic logic [PSUM_AWIDTH-1:0] sext_psum(input logic [PSUM_DWIDTH-1:0] d);
        return {{(PSUM_AWIDTH-PSUM_DWIDTH){d[PSUM_DWIDTH-1]}}, d};
    endfunction

endpackage

// File: rtl/psum_acc_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head (data + valid).
// A push while full is accepted only when a pop happens in the same cycle.
module psum_acc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             r_valid;

    logic             w_pop;
    logic             w_push_ok;
    logic [CW-1:0]    w_count_nxt;
    logic [PW-1:0]    w_rd_ptr_inc;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_pop        = i_pop && (r_count != '0);
    assign w_push_ok    = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    assign w_count_nxt  = r_count + CW'(w_push_ok) - CW'(w_pop);
    assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

    // Head register is loaded with whatever will sit at the read pointer after this cycle.
    always_comb begin
        w_head_nxt = r_rdata;
        if (w_pop) begin
            if (r_count > CW'(1)) begin
                w_head_nxt = r_mem[w_rd_ptr_inc];
            end else if (w_push_ok) begin
                w_head_nxt = i_wdata;
            end
        end else if ((r_count == '0) && w_push_ok) begin
            w_head_nxt = i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)     r_rd_ptr <= w_rd_ptr_inc;
            r_count <= w_count_nxt;
            r_rdata <= w_head_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_rdata;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/psum_acc_row.sv
// Channel-pass psum accumulator: sums cfg_npass passes per position, emits sums via an FWFT FIFO.
// Optional macro PSUM_ACC_RELU_EN clamps pushed sums at zero; the row buffer stays signed.
module psum_acc_row
    import psum_pkg::*;
#(
    parameter int DWIDTH      = PSUM_DWIDTH,
    parameter int AWIDTH      = PSUM_AWIDTH,
    parameter int DEPTH       = 64,
    parameter int NPW         = 8,
    parameter int FDEPTH      = 8,
    parameter int STALL_SLACK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NPW-1:0]    cfg_npass,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output psum_acc_state_t   o_dbg_state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(FDEPTH) + 1;

    psum_acc_state_t   r_state;
    psum_acc_state_t   w_state_nxt;
    logic [AWIDTH-1:0] r_buf [DEPTH];
    logic [PW-1:0]     r_pos;
    logic [NPW-1:0]    r_pass;
    logic [NPW-1:0]    r_npass;
    logic              r_err_ovf;
    logic              r_stall;

    logic              w_beat;
    logic              w_first_pass;
    logic              w_last_pass;
    logic              w_pos_wrap;
    logic [AWIDTH-1:0] w_x;
    logic [AWIDTH-1:0] w_sum;
    logic [AWIDTH-1:0] w_push_data;
    logic              w_push;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_nxt;
    logic              w_done;

    assign w_beat       = in_valid && (r_state == ACC);
    assign w_first_pass = (r_pass == '0);
    assign w_last_pass  = (r_pass == (r_npass - NPW'(1)));
    assign w_pos_wrap   = (r_pos == PW'(DEPTH - 1));
    assign w_x          = AWIDTH'(sext_psum(PSUM_DWIDTH'(in_data)));
    assign w_sum        = w_first_pass ? w_x : (r_buf[r_pos] + w_x);
    assign w_push       = w_beat && w_last_pass;
    assign w_pop        = out_valid && out_ready;
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_count_nxt  = w_count + CW'(w_push_ok) - CW'(w_pop);

`ifdef PSUM_ACC_RELU_EN
    assign w_push_data = w_sum[AWIDTH-1] ? '0 : w_sum;
`else
    assign w_push_data = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE:  if (start) w_state_nxt = ACC;
            ACC:   if (w_push && w_pos_wrap) w_state_nxt = DRAIN;
            DRAIN: if (w_empty) begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // start is only honoured from IDLE, so a stray pulse mid-tile cannot reload the pass count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos     <= '0;
            r_pass    <= '0;
            r_npass   <= NPW'(1);
            r_err_ovf <= 1'b0;
            r_stall   <= 1'b0;
        end else begin
            r_stall <= (w_count_nxt >= CW'(FDEPTH - STALL_SLACK));
            if ((r_state == IDLE) && start) begin
                r_pos     <= '0;
                r_pass    <= '0;
                r_npass   <= (cfg_npass == '0) ? NPW'(1) : cfg_npass;
                r_err_ovf <= 1'b0;
            end else begin
                if (w_beat) begin
                    if (w_pos_wrap) begin
                        r_pos  <= '0;
                        r_pass <= r_pass + NPW'(1);
                    end else begin
                        r_pos <= r_pos + PW'(1);
                    end
                end
                if (w_push && !w_push_ok) r_err_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat && !w_last_pass) r_buf[r_pos] <= w_sum;
    end

    psum_acc_fifo #(
        .WIDTH (AWIDTH),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (out_data),
        .o_valid (out_valid),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign stall       = r_stall;
    assign busy        = (r_state != IDLE);
    assign done        = w_done;
    assign err_ovf     = r_err_ovf;
    assign o_dbg_state = r_state;

endmodule
